rc4_prga_decrypt: RTL and testbench

- Downstream consumer of the ROM-reader stage in the RC4 breaker datapath.
- Inputs:
  - the full encrypted message array, held parallel by the ROM reader;
  - a 256-byte S memory already initialised and key-scheduled by the KSA stage.
- Runs the RC4 PRGA loop: i/j update, swap S[i]/S[j], fetch keystream byte f = S[(S[i]+S[j]) mod 256].
- XORs f with each message byte and writes the plaintext to the decrypted-message RAM. Signals done to the key-search controller.

---
 rtl/rc4_pkg.sv | 29 ++
 rtl/rc4_valid_char.sv | 19 +
 rtl/rc4_prga_decrypt.sv | 166 ++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA decrypt stage.
// CHAR_CHECK_EN enables the printable-plaintext abort in the top level.
package rc4_pkg;

  localparam int MSG_DEP = 32;
  localparam int BYTE_W  = 8;

  localparam logic [7:0] ASCII_A  = 8'd97;
  localparam logic [7:0] ASCII_Z  = 8'd122;
  localparam logic [7:0] ASCII_SP = 8'd32;

  typedef enum logic [3:0] {
    IDLE,
    INC_I,
    WAIT_SI,
    READ_SI,
    WAIT_SJ,
    READ_SJ,
    WR_SI,
    WR_SJ,
    ADDR_F,
    WAIT_F,
    READ_F,
    WR_D,
    NEXT,
    DONE
  } state_e;

endpackage

// File: rtl/rc4_valid_char.sv
// Plaintext byte filter: lowercase letters or space.
// Only instantiated when CHAR_CHECK_EN is defined.
module rc4_valid_char
  import rc4_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       ok_o
);

  always_comb begin
    ok_o = 1'b0;
    unique case (1'b1)
      (byte_i == ASCII_SP): ok_o = 1'b1;
      ((byte_i >= ASCII_A) && (byte_i <= ASCII_Z)): ok_o = 1'b1;
      default: ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA keystream generator and message XOR into the decrypted RAM.
// CHAR_CHECK_EN: abort with fail=1 on a non [a-z ] plaintext byte.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int DEP = MSG_DEP,
  parameter int WID = BYTE_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [WID-1:0] msg_data [0:DEP-1],
  output logic [7:0]     s_addr,
  output logic [7:0]     s_data,
  output logic           s_wren,
  input  logic [7:0]     s_q,
  output logic [7:0]     d_addr,
  output logic [WID-1:0] d_data,
  output logic           d_wren,
  output logic           done,
  output logic           fail
);

  localparam logic [7:0] LAST = 8'(DEP - 1);

  state_e     state_q;
  logic [7:0] i_q, j_q, k_q;
  logic [7:0] si_q, sj_q, f_q;

  logic [7:0]     j_d;
  logic [WID-1:0] msg_k;
  logic [WID-1:0] pt_d;

  assign j_d  = j_q + s_q;
  assign pt_d = f_q ^ msg_k;

  // Mux by k without an index narrower than k itself.
  always_comb begin
    msg_k = '0;
    for (int n = 0; n < DEP; n++) begin
      if (k_q == n[7:0]) msg_k = msg_data[n];
    end
  end

`ifdef CHAR_CHECK_EN
  logic ok;
  logic bad_q;

  rc4_valid_char u_chk (
    .byte_i (pt_d),
    .ok_o   (ok)
  );
`else
  assign fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      f_q     <= '0;
      s_addr  <= '0;
      s_data  <= '0;
      s_wren  <= 1'b0;
      d_addr  <= '0;
      d_data  <= '0;
      d_wren  <= 1'b0;
      done    <= 1'b0;
`ifdef CHAR_CHECK_EN
      fail    <= 1'b0;
      bad_q   <= 1'b0;
`endif
    end else begin
      s_wren <= 1'b0;
      d_wren <= 1'b0;
      unique case (state_q)
        IDLE: begin
          i_q  <= '0;
          j_q  <= '0;
          k_q  <= '0;
          done <= 1'b0;
`ifdef CHAR_CHECK_EN
          fail  <= 1'b0;
          bad_q <= 1'b0;
`endif
          if (start) state_q <= INC_I;
        end
        INC_I: begin
          i_q     <= i_q + 8'd1;
          s_addr  <= i_q + 8'd1;
          state_q <= WAIT_SI;
        end
        WAIT_SI: state_q <= READ_SI;
        READ_SI: begin
          si_q    <= s_q;
          j_q     <= j_d;
          s_addr  <= j_d;
          state_q <= WAIT_SJ;
        end
        WAIT_SJ: state_q <= READ_SJ;
        READ_SJ: begin
          sj_q    <= s_q;
          state_q <= WR_SI;
        end
        WR_SI: begin
          s_addr  <= j_q;
          s_data  <= si_q;
          s_wren  <= 1'b1;
          state_q <= WR_SJ;
        end
        WR_SJ: begin
          s_addr  <= i_q;
          s_data  <= sj_q;
          s_wren  <= 1'b1;
          state_q <= ADDR_F;
        end
        ADDR_F: begin
          s_addr  <= si_q + sj_q;
          state_q <= WAIT_F;
        end
        WAIT_F: state_q <= READ_F;
        READ_F: begin
          f_q     <= s_q;
          state_q <= WR_D;
        end
        WR_D: begin
          d_addr  <= k_q;
          d_data  <= pt_d;
          d_wren  <= 1'b1;
`ifdef CHAR_CHECK_EN
          bad_q   <= ~ok;
`endif
          state_q <= NEXT;
        end
        NEXT: begin
`ifdef CHAR_CHECK_EN
          if (bad_q) begin
            fail    <= 1'b1;
            done    <= 1'b1;
            state_q <= DONE;
          end else
`endif
          if (k_q == LAST) begin
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            k_q     <= k_q + 8'd1;
            state_q <= INC_I;
          end
        end
        DONE: begin
          if (!start) begin
            done    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt with behavioural S and D RAMs.
// Honours CHAR_CHECK_EN to exercise the abort path instead of full runs.
module tb_rc4_prga_decrypt;

  localparam int DEP = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] msg [0:DEP-1];
  logic [7:0] s_addr, s_data, s_q;
  logic       s_wren;
  logic [7:0] d_addr, d_data;
  logic       d_wren;
  logic       done, fail;

  logic [7:0] smem [256];
  logic [7:0] dmem [256];
  int         dcnt;
  int         errors = 0;
  int         checks = 0;
  int         n;

  rc4_prga_decrypt #(.DEP(DEP), .WID(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .msg_data (msg),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .s_wren   (s_wren),
    .s_q      (s_q),
    .d_addr   (d_addr),
    .d_data   (d_data),
    .d_wren   (d_wren),
    .done     (done),
    .fail     (fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_wren) smem[s_addr] = s_data;
    s_q <= smem[s_addr];
    if (d_wren) begin
      dmem[d_addr] = d_data;
      dcnt = dcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_s();
    for (int a = 0; a < 256; a++) begin
      smem[a] = 8'(a);
      dmem[a] = 8'h00;
    end
    dcnt = 0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_s_addr"}, {24'd0, s_addr}, 32'd0);
    chk({tag, "_s_data"}, {24'd0, s_data}, 32'd0);
    chk({tag, "_s_wren"}, {31'd0, s_wren}, 32'd0);
    chk({tag, "_d_addr"}, {24'd0, d_addr}, 32'd0);
    chk({tag, "_d_data"}, {24'd0, d_data}, 32'd0);
    chk({tag, "_d_wren"}, {31'd0, d_wren}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_fail"}, {31'd0, fail}, 32'd0);
  endtask

  // Raise start; returns just after the edge that samples it in IDLE.
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int a = 0; a < DEP; a++) msg[a] = 8'h00;
    init_s();
    repeat (3) @(posedge clk);
    #1;
    outs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

`ifdef CHAR_CHECK_EN
    kick();
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cc_done_edge", n, 12);
    chk("cc_fail", {31'd0, fail}, 1);
    chk("cc_d0", {24'd0, dmem[0]}, 32'h02);
    chk("cc_wr_cnt", dcnt, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("cc_hold_cnt", dcnt, 1);
    chk("cc_hold_done", {31'd0, done}, 1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("cc_idle_done", {31'd0, done}, 0);
    chk("cc_idle_fail", {31'd0, fail}, 0);
`else
    kick();
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 12) begin
        chk("swap1_s1", {24'd0, smem[1]}, 32'd1);
        chk("swap1_s0", {24'd0, smem[0]}, 32'd0);
        chk("b1_d0", {24'd0, dmem[0]}, 32'h02);
        chk("b1_cnt", dcnt, 1);
      end
      if (n == 24) begin
        chk("swap2_s2", {24'd0, smem[2]}, 32'd3);
        chk("swap2_s3", {24'd0, smem[3]}, 32'd2);
        chk("swap2_s4", {24'd0, smem[4]}, 32'd4);
        chk("swap2_s5", {24'd0, smem[5]}, 32'd5);
        chk("b2_d1", {24'd0, dmem[1]}, 32'h05);
      end
    end
    chk("done_edge", n, 384);
    chk("wr_cnt", dcnt, 32);
    chk("fail_off", {31'd0, fail}, 0);

    repeat (20) @(posedge clk);
    #1;
    chk("hold_done", {31'd0, done}, 1);
    chk("hold_cnt", dcnt, 32);
    chk("hold_wren", {31'd0, d_wren}, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("release_done", {31'd0, done}, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_cnt", dcnt, 32);

    init_s();
    msg[0] = 8'h63;
    msg[1] = 8'h60;
    kick();
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("msg_done_edge", n, 384);
    chk("msg_d0", {24'd0, dmem[0]}, 32'h61);
    chk("msg_d1", {24'd0, dmem[1]}, 32'h65);
    @(negedge clk);
    start = 1'b0;
    msg[0] = 8'h00;
    msg[1] = 8'h00;
    repeat (2) @(posedge clk);

    init_s();
    kick();
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    outs_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_idle_cnt", dcnt, 0);
    chk("rst_idle_done", {31'd0, done}, 0);

    init_s();
    kick();
    repeat (12) @(posedge clk);
    #1;
    chk("restart_d0", {24'd0, dmem[0]}, 32'h02);
    chk("restart_cnt", dcnt, 1);
    chk("restart_s1", {24'd0, smem[1]}, 32'd1);
    @(negedge clk);
    start = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
